mem_req_arbiter: RTL and testbench

Two-to-one arbiter for the CPU's SRAM-like memory ports. It merges the instruction requester (read-only) and the data requester (read/write) onto a single SRAM-like master port that feeds the AXI bridge. It tracks up to `OUTSTANDING` in-flight transactions in an owner FIFO so each `data_ok`/`rdata` beat returns to the requester that issued it. Data has fixed priority over instruction fetch, with a bounded-starvation guarantee for instruction fetch.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/arb_owner_fifo.sv | 57 +++++
 rtl/mem_req_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_req_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory request arbiter.
// Owner tags identify which requester issued each in-flight transaction.
package mem_arb_pkg;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam int ARB_OUTSTANDING  = 4;
    localparam int ARB_MAX_DATA_RUN = 3;

endpackage

// File: rtl/arb_owner_fifo.sv
// Owner FIFO: remembers, in issue order, which requester owns each
// outstanding transaction so responses can be routed back.
module arb_owner_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = ARB_OUTSTANDING
) (
    input  logic   aclk,
    input  logic   aresetn,
    input  logic   push,
    input  owner_t din,
    input  logic   pop,
    output owner_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    owner_t        mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head  = mem[rptr];
    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-to-one SRAM-like arbiter: data has priority, instruction fetch is
// guaranteed a grant after a bounded run of data grants.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int OUTSTANDING  = ARB_OUTSTANDING,
    parameter int MAX_DATA_RUN = ARB_MAX_DATA_RUN
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wstrb,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,
    output logic        err_spurious
);

    localparam int RW = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DATA_RUN);

    owner_t        sel;
    owner_t        lock_owner;
    owner_t        head;
    logic          sel_vld;
    logic          sel_req;
    logic          lock;
    logic          fifo_full;
    logic          fifo_empty;
    logic          hs;
    logic          pop;
    logic [RW-1:0] run_cnt;
    logic          unused_inst_wr;

    assign unused_inst_wr = inst_wr;

    // A stalled request keeps the port until its handshake completes.
    always_comb begin
        sel     = OWN_INST;
        sel_vld = 1'b0;
        if (lock) begin
            sel     = lock_owner;
            sel_vld = 1'b1;
        end else if (data_req && !(inst_req && run_cnt == RUN_MAX)) begin
            sel     = OWN_DATA;
            sel_vld = 1'b1;
        end else if (inst_req) begin
            sel     = OWN_INST;
            sel_vld = 1'b1;
        end
    end

    assign sel_req = sel_vld & ((sel == OWN_DATA) ? data_req : inst_req);
    assign m_req   = sel_req & ~fifo_full;
    assign hs      = m_req & m_addr_ok;
    assign pop     = m_data_ok & ~fifo_empty;

    assign m_wr    = (sel == OWN_DATA) & data_wr;
    assign m_size  = (sel == OWN_DATA) ? data_size  : inst_size;
    assign m_wstrb = (sel == OWN_DATA) ? data_wstrb : inst_wstrb;
    assign m_addr  = (sel == OWN_DATA) ? data_addr  : inst_addr;
    assign m_wdata = (sel == OWN_DATA) ? data_wdata : inst_wdata;

    assign inst_addr_ok = hs & (sel == OWN_INST);
    assign data_addr_ok = hs & (sel == OWN_DATA);
    assign inst_data_ok = pop & (head == OWN_INST);
    assign data_data_ok = pop & (head == OWN_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lock         <= 1'b0;
            lock_owner   <= OWN_INST;
            run_cnt      <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (hs) begin
                lock <= 1'b0;
            end else if (m_req) begin
                lock       <= 1'b1;
                lock_owner <= sel;
            end
            if (!inst_req || (hs && sel == OWN_INST)) begin
                run_cnt <= '0;
            end else if (hs && run_cnt != RUN_MAX) begin
                run_cnt <= run_cnt + 1'b1;
            end
            if (m_data_ok && fifo_empty) begin
                err_spurious <= 1'b1;
            end
        end
    end

    arb_owner_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_owner_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (hs),
        .din     (sel),
        .pop     (pop),
        .head    (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: directed scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_mem_req_arbiter;

    import mem_arb_pkg::*;

    localparam int OUT  = 4;
    localparam int MAXR = 3;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, m_size;
    logic [3:0]  inst_wstrb, data_wstrb, m_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr, m_addr_ok, m_data_ok, err_spurious;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always #5 aclk = ~aclk;

    mem_req_arbiter #(.OUTSTANDING(OUT), .MAX_DATA_RUN(MAXR)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .err_spurious(err_spurious)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner queue, stalled winner, data streak, error flag.
    int q[$];
    int lockw = -1;
    int streak = 0;
    bit err_m = 1'b0;

    int last_hs;
    bit got_mreq, got_id, got_dd;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        lockw  = -1;
        streak = 0;
        err_m  = 1'b0;
    endtask

    task automatic step();
        int who;
        bit sreq, mreq, hs, pop;
        @(negedge aclk);
        who = -1;
        if (lockw >= 0) who = lockw;
        else if (data_req && !(inst_req && streak == MAXR)) who = 1;
        else if (inst_req) who = 0;
        sreq = (who == 1) ? data_req : ((who == 0) ? inst_req : 1'b0);
        mreq = sreq && (q.size() < OUT);
        hs   = mreq && m_addr_ok;
        pop  = m_data_ok && (q.size() > 0);
        got_mreq = m_req;
        got_id   = inst_data_ok;
        got_dd   = data_data_ok;
        chk("m_req", m_req, mreq);
        chk("inst_addr_ok", inst_addr_ok, hs && who == 0);
        chk("data_addr_ok", data_addr_ok, hs && who == 1);
        chk("inst_data_ok", inst_data_ok, pop && q[0] == 0);
        chk("data_data_ok", data_data_ok, pop && q[0] == 1);
        chk("err_spurious", err_spurious, err_m);
        chk("inst_rdata", inst_rdata, m_rdata);
        chk("data_rdata", data_rdata, m_rdata);
        if (mreq) begin
            chk("m_addr", m_addr, (who == 1) ? data_addr : inst_addr);
            chk("m_wdata", m_wdata, (who == 1) ? data_wdata : inst_wdata);
            chk("m_size", m_size, (who == 1) ? data_size : inst_size);
            chk("m_wstrb", m_wstrb, (who == 1) ? data_wstrb : inst_wstrb);
            chk("m_wr", m_wr, (who == 1) && data_wr);
        end
        last_hs = hs ? who : -1;
        if (m_data_ok && q.size() == 0) err_m = 1'b1;
        if (pop) void'(q.pop_front());
        if (hs) begin
            q.push_back(who);
            lockw = -1;
        end else if (mreq) begin
            lockw = who;
        end
        if (!inst_req || (hs && who == 0)) streak = 0;
        else if (hs && who == 1 && streak < MAXR) streak++;
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn   = 1'b0;
        inst_req  = 1'b0;
        data_req  = 1'b0;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        model_reset();
        @(negedge aclk);
        chk("rst_m_req", m_req, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        chk("rst_data_data_ok", data_data_ok, 0);
        chk("rst_err", err_spurious, 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic drain();
        inst_req  = 1'b0;
        data_req  = 1'b0;
        m_addr_ok = 1'b0;
        repeat (OUT + 1) begin
            m_data_ok = (q.size() > 0);
            m_rdata   = $urandom;
            step();
        end
        m_data_ok = 1'b0;
    endtask

    initial begin
        inst_wr = 1'b0; inst_size = 2'd2; inst_wstrb = 4'hf;
        inst_addr = '0; inst_wdata = '0;
        data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'hf;
        data_addr = '0; data_wdata = '0;
        m_rdata = '0;
        do_reset();

        // Instruction read alone
        inst_req = 1'b1; inst_addr = 32'h1C00_0000; m_addr_ok = 1'b1;
        step();
        chk("t1_grant", last_hs, 0);
        inst_req = 1'b0; m_addr_ok = 1'b0;
        step();
        m_data_ok = 1'b1; m_rdata = 32'h0280_0000;
        step();
        chk("t1_inst_data_ok", got_id, 1);
        chk("t1_data_data_ok", got_dd, 0);
        m_data_ok = 1'b0;
        step();

        // Simultaneous requests: data first
        inst_req = 1'b1; inst_addr = 32'h1C00_0004;
        data_req = 1'b1; data_addr = 32'h80; data_wr = 1'b0;
        m_addr_ok = 1'b1;
        step();
        chk("t2_first", last_hs, 1);
        data_req = 1'b0;
        step();
        chk("t2_second", last_hs, 0);
        inst_req = 1'b0; m_addr_ok = 1'b0;
        m_data_ok = 1'b1; m_rdata = 32'hAAAA;
        step();
        chk("t2_rsp1_data", got_dd, 1);
        m_rdata = 32'hBBBB;
        step();
        chk("t2_rsp2_inst", got_id, 1);
        m_data_ok = 1'b0;

        // Starvation bound: D,D,D,I repeating
        do_reset();
        inst_req = 1'b1; data_req = 1'b1; m_addr_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m_data_ok = (q.size() > 0);
            step();
            chk("t3_seq", last_hs, (i % 4 == 3) ? 0 : 1);
        end
        drain();

        // Lock holds a stalled instruction request
        inst_req = 1'b1; inst_addr = 32'h1C00_0040; m_addr_ok = 1'b0;
        step();
        data_req = 1'b1; data_addr = 32'h100;
        step();
        step();
        chk("t4_locked_addr", m_addr, 32'h1C00_0040);
        m_addr_ok = 1'b1;
        step();
        chk("t4_inst_hs", last_hs, 0);
        inst_req = 1'b0;
        step();
        chk("t4_data_hs", last_hs, 1);
        drain();

        // FIFO full blocks the port, even on a same-cycle pop
        inst_req = 1'b1; m_addr_ok = 1'b1;
        for (int i = 0; i < OUT; i++) begin
            inst_addr = 32'h1C00_0100 + 32'(4 * i);
            step();
        end
        step();
        chk("t5_full_block", got_mreq, 0);
        m_data_ok = 1'b1;
        step();
        chk("t5_pop_block", got_mreq, 0);
        m_data_ok = 1'b0;
        step();
        chk("t5_regrant", last_hs, 0);
        drain();

        // Reset with transactions in flight
        inst_req = 1'b1; m_addr_ok = 1'b1;
        step();
        step();
        do_reset();
        m_data_ok = 1'b1;
        step();
        chk("t6_no_inst_ok", got_id, 0);
        chk("t6_no_data_ok", got_dd, 0);
        m_data_ok = 1'b0;
        step();
        chk("t6_err_sticky", err_spurious, 1);
        step();

        // Random traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if (!inst_req && $urandom_range(0, 2) == 0) begin
                inst_req   = 1'b1;
                inst_wr    = 1'($urandom);
                inst_size  = 2'($urandom);
                inst_wstrb = 4'($urandom);
                inst_addr  = $urandom;
                inst_wdata = $urandom;
            end
            if (!data_req && $urandom_range(0, 2) == 0) begin
                data_req   = 1'b1;
                data_wr    = 1'($urandom);
                data_size  = 2'($urandom);
                data_wstrb = 4'($urandom);
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            m_addr_ok = ($urandom_range(0, 3) != 0);
            m_data_ok = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            m_rdata   = $urandom;
            step();
            if (last_hs == 0) inst_req = 1'b0;
            if (last_hs == 1) data_req = 1'b0;
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
